// File: rtl/ibex_multdiv_pkg.sv
// rtl/ibex_multdiv_pkg.sv - shared types for the multdiv sequencer/arbiter
package ibex_multdiv_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RUN  = 2'd1,
    ARB_KILL = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  // Multiply ops use the multiplier enable, everything else the divider enable.
  function automatic logic md_op_is_mult(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_md_rr_arb.sv
// rtl/ibex_md_rr_arb.sv - combinational two-way round-robin grant
module ibex_md_rr_arb (
  input  logic [1:0] valid_i,
  input  logic [1:0] flush_i,
  input  logic       ptr_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic [1:0] cand;

  // A requester being flushed this cycle is not eligible; ties go to the pointer.
  always_comb begin
    cand        = valid_i & ~flush_i;
    gnt_valid_o = |cand;
    gnt_idx_o   = (&cand) ? ptr_i : cand[1];
  end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// rtl/ibex_multdiv_arbiter.sv - sequences and shares one multdiv datapath between two requesters
module ibex_multdiv_arbiter
  import ibex_multdiv_pkg::*;
#(
  parameter bit RR_RESET_PTR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][1:0]  req_op_i,
  input  logic [1:0][1:0]  req_signed_mode_i,
  input  logic [1:0][31:0] req_op_a_i,
  input  logic [1:0][31:0] req_op_b_i,
  input  logic [1:0]       flush_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic [1:0]       md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  input  logic [31:0]      md_result_i,
  input  logic             md_ready_i,
  output logic             busy_o,
  output logic             owner_o
);

  localparam logic [1:0] StIdle = ARB_IDLE;
  localparam logic [1:0] StRun  = ARB_RUN;
  localparam logic [1:0] StKill = ARB_KILL;
  localparam logic [1:0] StResp = ARB_RESP;

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  md_op_e      op_q, op_d;
  logic [1:0]  sm_q, sm_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;

  logic        gnt_valid;
  logic        gnt_idx;
  logic        run_en;

  ibex_md_rr_arb u_rr_arb (
    .valid_i     (req_valid_i),
    .flush_i     (flush_i),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Next-state logic: accept in IDLE, run (or kill) the datapath to completion, then respond.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    sm_d        = sm_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    run_en      = 1'b0;

    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          req_ready_o[gnt_idx] = 1'b1;
          owner_d = gnt_idx;
          op_d    = md_op_e'(req_op_i[gnt_idx]);
          sm_d    = req_signed_mode_i[gnt_idx];
          a_d     = req_op_a_i[gnt_idx];
          b_d     = req_op_b_i[gnt_idx];
          state_d = StRun;
        end
      end

      StRun: begin
        run_en = 1'b1;
        // A flush always wins over a completion in the same cycle.
        if (flush_i[owner_q]) begin
          if (md_ready_i) begin
            state_d = StIdle;
            ptr_d   = ~owner_q;
          end else begin
            state_d = StKill;
          end
        end else if (md_ready_i) begin
          res_d   = md_result_i;
          state_d = StResp;
        end
      end

      StKill: begin
        // Keep the datapath enabled so it returns to its own idle state.
        run_en = 1'b1;
        if (md_ready_i) begin
          state_d = StIdle;
          ptr_d   = ~owner_q;
        end
      end

      StResp: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q] || flush_i[owner_q]) begin
          state_d = StIdle;
          ptr_d   = ~owner_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // FSM, round-robin pointer and latched operation/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= RR_RESET_PTR;
      owner_q <= 1'b0;
      op_q    <= MD_OP_MULL;
      sm_q    <= 2'b00;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      res_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      sm_q    <= sm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign md_mult_en_o     = run_en & md_op_is_mult(op_q);
  assign md_div_en_o      = run_en & ~md_op_is_mult(op_q);
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sm_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign rsp_result_o     = res_q;
  assign busy_o           = (state_q != StIdle);
  assign owner_o          = owner_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// tb/tb_ibex_multdiv_arbiter.sv - self-checking bench for ibex_multdiv_arbiter
module tb_ibex_multdiv_arbiter;
  import ibex_multdiv_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][1:0]  req_op_i;
  logic [1:0][1:0]  req_signed_mode_i;
  logic [1:0][31:0] req_op_a_i;
  logic [1:0][31:0] req_op_b_i;
  logic [1:0]       flush_i;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic             md_mult_en_o;
  logic             md_div_en_o;
  logic [1:0]       md_operator_o;
  logic [1:0]       md_signed_mode_o;
  logic [31:0]      md_op_a_o;
  logic [31:0]      md_op_b_o;
  logic [31:0]      md_result_i;
  logic             md_ready_i;
  logic             busy_o;
  logic             owner_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ibex_multdiv_arbiter #(.RR_RESET_PTR(1'b0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_signed_mode_i (req_signed_mode_i),
    .req_op_a_i        (req_op_a_i),
    .req_op_b_i        (req_op_b_i),
    .flush_i           (flush_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_result_o      (rsp_result_o),
    .md_mult_en_o      (md_mult_en_o),
    .md_div_en_o       (md_div_en_o),
    .md_operator_o     (md_operator_o),
    .md_signed_mode_o  (md_signed_mode_o),
    .md_op_a_o         (md_op_a_o),
    .md_op_b_o         (md_op_b_o),
    .md_result_i       (md_result_i),
    .md_ready_i        (md_ready_i),
    .busy_o            (busy_o),
    .owner_o           (owner_o)
  );

  // Behavioural iterative datapath: completes dp_lat cycles after its enable rises.
  function automatic logic [31:0] dp_calc(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb, pr;
    ea = sm[0] ? {{34{a[31]}}, a} : {34'b0, a};
    eb = sm[1] ? {{34{b[31]}}, b} : {34'b0, b};
    pr = ea * eb;
    case (op)
      2'd0: return pr[31:0];
      2'd1: return pr[63:32];
      2'd2: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (sm != 2'b00) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
          return $signed(a) / $signed(b);
        end
        return a / b;
      end
      default: begin
        if (b == 32'h0) return a;
        if (sm != 2'b00) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
          return $signed(a) % $signed(b);
        end
        return a % b;
      end
    endcase
  endfunction

  int   dp_lat = 2;
  int   dp_cnt;
  logic dp_en;
  assign dp_en       = md_mult_en_o | md_div_en_o;
  assign md_ready_i  = dp_en && (dp_cnt == dp_lat);
  assign md_result_i = dp_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_cnt <= 0;
    else if (dp_en && !md_ready_i) dp_cnt <= dp_cnt + 1;
    else dp_cnt <= 0;
  end

  typedef struct {
    bit          idx;
    logic [31:0] res;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          idx;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit idx, input logic [31:0] res);
    sb_t e;
    e.idx = idx;
    e.res = res;
    sb_q.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin : rsp_mon
    sb_t e;
    if (rst_n && ((rsp_valid_o & rsp_ready_i) != 2'b00)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", {30'b0, rsp_valid_o}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_owner", {30'b0, rsp_valid_o}, e.idx ? 32'h2 : 32'h1);
        chk("rsp_result", rsp_result_o, e.res);
      end
    end
  end

  task automatic send(input bit idx, input logic [1:0] op, input logic [1:0] sm,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input bit expect_rsp);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_op_i[idx] = op;
    req_signed_mode_i[idx] = sm;
    req_op_a_i[idx] = a;
    req_op_b_i[idx] = b;
    req_valid_i[idx] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready_o[idx]) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    else if (expect_rsp) push_exp(idx, exp);
    @(posedge clk); #1;
    req_valid_i[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (!busy_o && sb_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_gnt;
    bit         seen;
    bit         bad_flag;
    int         en_cycles;

    req_valid_i = '0; req_op_i = '0; req_signed_mode_i = '0;
    req_op_a_i = '0; req_op_b_i = '0; flush_i = '0; rsp_ready_i = 2'b11;

    vecs[0] = '{1'b1, 2'd2, 2'd0, 32'd5,        32'd0,        32'hFFFFFFFF, 4};
    vecs[1] = '{1'b1, 2'd3, 2'd0, 32'd5,        32'd0,        32'd5,        4};
    vecs[2] = '{1'b0, 2'd1, 2'd3, 32'h80000000, 32'd2,        32'hFFFFFFFF, 2};
    vecs[3] = '{1'b0, 2'd1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3};
    vecs[4] = '{1'b1, 2'd2, 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5};
    vecs[5] = '{1'b0, 2'd3, 2'd3, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 2};
    vecs[6] = '{1'b1, 2'd0, 2'd0, 32'h12345678, 32'h10,       32'h23456780, 1};
    vecs[7] = '{1'b0, 2'd2, 2'd0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_req_ready", {30'b0, req_ready_o}, 32'h0);
    chk("rst_rsp_valid", {30'b0, rsp_valid_o}, 32'h0);
    chk("rst_en", {30'b0, md_mult_en_o, md_div_en_o}, 32'h0);
    chk("rst_op_a", md_op_a_o, 32'h0);
    chk("rst_result", rsp_result_o, 32'h0);
    chk("rst_owner", {31'b0, owner_o}, 32'h0);
    rst_n = 1'b1;

    // Both valid from reset: grants alternate 0,1,0,1.
    dp_lat = 3;
    @(posedge clk); #1;
    req_op_i[0] = 2'd2; req_signed_mode_i[0] = 2'd0; req_op_a_i[0] = 32'd100; req_op_b_i[0] = 32'd7;
    req_op_i[1] = 2'd3; req_signed_mode_i[1] = 2'd3; req_op_a_i[1] = 32'hFFFFFFF9; req_op_b_i[1] = 32'd2;
    req_valid_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_gnt = (g % 2 == 0) ? 2'b01 : 2'b10;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (req_ready_o != 2'b00) seen = 1'b1;
      end
      chk("rr_grant", {30'b0, req_ready_o}, {30'b0, exp_gnt});
      if (exp_gnt == 2'b01) push_exp(1'b0, 32'd14);
      else push_exp(1'b1, 32'hFFFFFFFF);
      @(posedge clk); #1;
    end
    req_valid_i = 2'b00;
    wait_idle();

    // MULL with enable-window timing.
    dp_lat = 3;
    send(1'b0, 2'd0, 2'd3, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    chk("en_at_accept_plus1", {31'b0, md_mult_en_o}, 32'h1);
    chk("latched_op_b", md_op_b_o, 32'hFFFFFFFD);
    en_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (md_mult_en_o) en_cycles++;
      if (md_ready_i) seen = 1'b1;
    end
    chk("en_cycles", en_cycles, dp_lat + 1);
    @(negedge clk);
    chk("en_low_in_resp", {31'b0, md_mult_en_o}, 32'h0);
    chk("rsp_valid_after_ready", {30'b0, rsp_valid_o}, 32'h1);
    wait_idle();

    // Table-driven operations.
    for (int v = 0; v < 8; v++) begin
      dp_lat = vecs[v].lat;
      send(vecs[v].idx, vecs[v].op, vecs[v].sm, vecs[v].a, vecs[v].b, vecs[v].exp, 1'b1);
      wait_idle();
    end

    // Flush of owner 0 during RUN of MULH, req1 pending.
    dp_lat = 6;
    send(1'b0, 2'd1, 2'd3, 32'h00001234, 32'h00005678, 32'h0, 1'b0);
    req_op_i[1] = 2'd3; req_signed_mode_i[1] = 2'd0; req_op_a_i[1] = 32'd5; req_op_b_i[1] = 32'd0;
    req_valid_i[1] = 1'b1;
    @(posedge clk); #1;
    flush_i = 2'b01;
    @(posedge clk); #1;
    flush_i = 2'b00;
    bad_flag = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (!md_mult_en_o || rsp_valid_o != 2'b00 || req_ready_o != 2'b00) bad_flag = 1'b1;
      if (md_ready_i) seen = 1'b1;
    end
    chk("kill_en_held", {31'b0, bad_flag}, 32'h0);
    chk("kill_busy_at_ready", {31'b0, busy_o}, 32'h1);
    @(negedge clk);
    chk("kill_busy_drop", {31'b0, busy_o}, 32'h0);
    chk("kill_next_accept", {30'b0, req_ready_o}, 32'h2);
    push_exp(1'b1, 32'd5);
    @(posedge clk); #1;
    req_valid_i[1] = 1'b0;
    wait_idle();

    // Response backpressure on requester 1 with requester 0 waiting.
    dp_lat = 2;
    rsp_ready_i = 2'b01;
    send(1'b1, 2'd2, 2'd0, 32'd100, 32'd7, 32'd14, 1'b1);
    req_op_i[0] = 2'd0; req_signed_mode_i[0] = 2'd0; req_op_a_i[0] = 32'd6; req_op_b_i[0] = 32'd9;
    req_valid_i[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid_o[1]) seen = 1'b1;
    end
    chk("hold_rsp_seen", {31'b0, seen}, 32'h1);
    bad_flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result", rsp_result_o, 32'd14);
      if (req_ready_o != 2'b00 || rsp_valid_o != 2'b10) bad_flag = 1'b1;
    end
    chk("hold_no_accept", {31'b0, bad_flag}, 32'h0);
    @(posedge clk); #1;
    rsp_ready_i = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("release_idle", {31'b0, busy_o}, 32'h0);
    chk("release_accept0", {30'b0, req_ready_o}, 32'h1);
    push_exp(1'b0, 32'd54);
    @(posedge clk); #1;
    req_valid_i[0] = 1'b0;
    wait_idle();

    // Asynchronous reset during RUN.
    dp_lat = 20;
    send(1'b0, 2'd2, 2'd0, 32'd1000, 32'd3, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'h0);
    chk("arst_en", {30'b0, md_mult_en_o, md_div_en_o}, 32'h0);
    chk("arst_op_a", md_op_a_o, 32'h0);
    chk("arst_operator", {30'b0, md_operator_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dp_lat = 2;
    send(1'b1, 2'd0, 2'd0, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_idle();

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_multdiv_arbiter.md
# ibex_multdiv_arbiter

Sequencer and two-way arbiter that shares a single iterative multiplier/divider (the slow multdiv datapath plus its ALU adder) between two requesters, e.g. the core's ID/EX stage and a coprocessor port. It accepts one operation at a time with a valid/ready request handshake and holds operands stable for the whole operation. It drives the datapath's enables, captures the result into a register, and returns it on a per-requester valid/ready response channel. Per-requester flush is supported without corrupting the shared datapath's internal state.

## Interface
Parameters:
- RR_RESET_PTR, default 0: requester holding round-robin priority after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  2  per-requester operation request
- req_ready_o  out  2  request accepted (one-hot or zero)
- req_op_i  in  2x2  md_op_e per requester
- req_signed_mode_i  in  2x2  {b_signed, a_signed} per requester
- req_op_a_i, req_op_b_i  in  2x32  operands per requester
- flush_i  in  2  per-requester kill
- rsp_valid_o  out  2  result available to requester
- rsp_ready_i  in  2  requester takes result
- rsp_result_o  out  32  result (shared bus, qualified by rsp_valid_o)
- md_mult_en_o, md_div_en_o  out  1  datapath enables
- md_operator_o  out  2  md_op_e to datapath
- md_signed_mode_o  out  2  to datapath
- md_op_a_o, md_op_b_o  out  32  latched operands
- md_result_i  in  32  datapath result
- md_ready_i  in  1  datapath completion
- busy_o  out  1  state != IDLE
- owner_o  out  1  index of current owner

## Operation
- FSM states: IDLE, RUN, KILL, RESP.
- IDLE: winner is the valid, non-flushed requester. If both are valid, priority pointer `ptr` decides. req_ready_o[winner]=1 combinationally. On handshake: latch op, signed mode, a, b, and owner; go RUN.
- RUN: md_mult_en_o=1 for MULL/MULH, md_div_en_o=1 for DIV/REM. Enable stays high through the md_ready_i cycle.
  - On md_ready_i: capture md_result_i into res_q; go RESP.
  - flush_i[owner] in RUN: go KILL (enable stays asserted).
- KILL: same enables as RUN. The datapath must run to completion, because dropping the enable would leave it in a non-idle state. On md_ready_i, discard the result and go IDLE.
- RESP: rsp_valid_o[owner]=1 and rsp_result_o=res_q, held stable until rsp_ready_i[owner].
  - On handshake: go IDLE, ptr <= ~owner.
  - flush_i[owner] in RESP: drop the response, go IDLE, ptr <= ~owner.
- Killed operations also set ptr <= ~owner on return to IDLE.
- flush_i[i] in IDLE masks requester i from arbitration that cycle.
- Enables are 0 in IDLE and RESP. md_* operand outputs always reflect the latched registers.
- Datapath semantics (div-by-zero gives all-ones quotient and remainder = dividend; signed overflow) are owned by the datapath and passed through unchanged.

## Timing
- Reset: state IDLE, ptr=RR_RESET_PTR, all outputs 0, latched registers 0.
- Accept at cycle T. Enable is high from T+1 (registered state).
- rsp_valid_o rises the cycle after md_ready_i.
- Added latency versus the bare datapath: +1 cycle at start, +1 at end.
- Earliest next accept is the cycle after the response handshake. No accept occurs during RESP or KILL.
- Flush and md_ready_i in the same RUN cycle: the result is discarded and the FSM goes IDLE (flush wins).
- rsp_ready_i deasserted: RESP holds indefinitely, and res_q and rsp_result_o stay stable.
- Reset asserted mid-operation: all state is cleared asynchronously. The datapath is reset by the same rst_n.

## Structure
- Shared package ibex_multdiv_pkg:
  - md_op_e (MULL=0, MULH=1, DIV=2, REM=3)
  - arb_state_e (IDLE, RUN, KILL, RESP)
- Sub-module ibex_md_rr_arb: combinational two-way round-robin grant from valid & ~flush and ptr. The pointer register stays in the parent.

## Test plan
- Req0 MULL a=7, b=0xFFFFFFFD, signed_mode=3 -> rsp_valid_o[0] with 0xFFFFFFEB; enable high from accept+1 until the md_ready_i cycle.
- Both valid at reset (ptr=0), req0 DIV 100/7, req1 REM a=0xFFFFFFF9, b=2, signed -> req0 gets 14 first, then req1 gets 0xFFFFFFFF; ptr toggles after each.
- Req1 DIV 5/0 unsigned -> result 0xFFFFFFFF; REM 5/0 -> 5.
- flush_i[0] mid-RUN of MULH -> enable held until md_ready_i, no rsp_valid_o, busy_o drops the cycle after, and a pending req1 is then accepted.
- rsp_ready_i[1] held low 10 cycles in RESP -> rsp_result_o stable, req_ready_o stays 0 for req0; release -> IDLE the next cycle.
- rst_n pulsed low during RUN -> all outputs 0 immediately, and a new request is accepted after reset release.
